mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single byte-wide unified RAM port between the instruction-fetch stage (IF) and the memory-access stage (MEM). Each 1/2/4-byte request becomes a sequence of byte accesses. Read bytes are assembled little-endian and returned with a one-cycle done pulse. While a MEM access is outstanding, the block drives the stall request into the central stall controller. MEM has priority over IF when both request in the same cycle.

## Interface
Parameters:
- ADDR_W, 32, address width of requests and the RAM port
- DATA_W, 32, request data width (4 bytes)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF fetch request; always a 4-byte read
- if_addr  in  ADDR_W  fetch address; held stable while if_req is high
- if_flush  in  1  abort the in-flight or pending fetch (branch redirect)
- if_done  out  1  one-cycle pulse; if_rdata is valid in the same cycle
- if_rdata  out  DATA_W  fetched instruction word
- mem_req  in  1  MEM access request
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes
- mem_addr  in  ADDR_W  access address; held stable while mem_req is high
- mem_wdata  in  DATA_W  store data; byte k is written to addr+k
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  load data, zero-extended; valid with mem_done
- mem_stall_request  out  1  to the stall controller; equals mem_req & ~mem_done
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write enable
- ram_dout  out  8  RAM write data
- ram_din  in  8  RAM read data; reflects the ram_a presented in the previous cycle

## Operation
- States are IDLE, IF_BUSY and MEM_BUSY. A byte counter cnt (3 bits) holds the number of addresses issued. The target count n is 1, 2 or 4, latched with the request.
- IDLE accept rules:
  - A request that is high at an edge where if_done and mem_done are both low is accepted.
  - If mem_req is high, go to MEM_BUSY; otherwise, if if_req is high and if_flush is low, go to IF_BUSY.
  - On accept, latch addr, we, n and wdata, and set cnt = 0 and the assembly register to 0.
- In a BUSY state:
  - ram_a = latched addr + cnt (ADDR_W-bit wrap-around add).
  - Stores: ram_wr = 1 and ram_dout = wdata byte cnt.
  - For cnt < n, cnt increments every cycle.
  - Loads: while cnt ≥ 1, ram_din is captured into assembly byte (cnt−1).
- Completion:
  - A load finishes at the edge that captures byte n−1. A store finishes at the edge after its last write cycle.
  - At that edge: state goes to IDLE, the done pulse registers high for exactly one cycle, and rdata registers the assembled word.
- Outputs in IDLE: ram_a = 0, ram_wr = 0, ram_dout = 0.
- Flush:
  - if_flush high in IF_BUSY: go to IDLE at the next edge, with no if_done and if_rdata unchanged.
  - if_flush has no effect on MEM_BUSY.
- A request arriving while the other requester is BUSY waits, with no loss and no reordering. MEM wins at the next accept edge.
- Stores never produce an if_done. if_rdata and mem_rdata hold their value until the next respective done.

## Timing
- Reset (async, any state including mid-access): state = IDLE, cnt = 0. All outputs are 0: if_done, mem_done, if_rdata, mem_rdata, ram_a, ram_wr and ram_dout. The partial access is discarded and RAM writes stop at once.
- Accept edge E0 (request sampled in IDLE). Address k is driven in cycle E0+1+k.
- Load of n bytes:
  - Byte k is captured at the edge ending cycle E0+2+k.
  - done is high in cycle E0+n+2. 4-byte fetch latency = 6 cycles from the accept edge.
- Store of n bytes: writes occur in cycles E0+1..E0+n, and done is high in cycle E0+n+1.
- Requesters must deassert or change their request in the done cycle. The arbiter never accepts in a done cycle, giving one idle turnaround cycle between back-to-back accesses.
- mem_stall_request is combinational. It drops in the mem_done cycle so the pipeline advances on that edge.

## Test plan
- Reset then IF fetch: RAM[0x100..0x103] = 13 05 a0 00, if_req with addr 0x100. Required: ram_a = 0x100..0x103 in 4 consecutive cycles, if_done 6 cycles after the accept edge, if_rdata = 0x00a00513.
- Store word then load half: sw 0xdeadbeef to 0x200 gives ram_wr in 4 cycles with bytes ef be ad de, and mem_done at E0+5. lh from 0x202 gives mem_rdata = 0x0000dead at E0+4.
- Simultaneous if_req and mem_req (lb from 0x10) in IDLE: MEM is served first. IF is accepted one turnaround cycle after mem_done. mem_stall_request is high until the mem_done cycle.
- if_flush asserted 2 cycles into a fetch: return to IDLE, no if_done, if_rdata unchanged. A new fetch to 0x104 completes normally.
- rst pulsed mid-store, after 2 of 4 bytes: ram_wr drops immediately, only 2 bytes are modified, all outputs read 0, and the next request starts from IDLE.
- Address wrap: a 4-byte load at 0xFFFFFFFE gives ram_a = FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the unified RAM port: MEM beats IF, each request becomes
// n byte accesses, read bytes are assembled little-endian and returned with a done pulse.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall_request,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic [2:0] size_n;
  logic [1:0] cap_idx;
  logic       busy;

  assign size_n  = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;
  // RAM data lags the address by a cycle, so the byte arriving now belongs to cnt-1.
  assign cap_idx = cnt_q[1:0] - 2'd1;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        // Never accept in a done cycle: requesters need that cycle to drop their request.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            state_d = MEM_BUSY;
            addr_d  = mem_addr;
            we_d    = mem_we;
            n_d     = size_n;
            wdata_d = mem_wdata;
            cnt_d   = '0;
            asm_d   = '0;
          end else if (if_req && !if_flush) begin
            state_d = IF_BUSY;
            addr_d  = if_addr;
            we_d    = 1'b0;
            n_d     = 3'd4;
            wdata_d = '0;
            cnt_d   = '0;
            asm_d   = '0;
          end
        end
      end
      default: begin
        if (state_q == IF_BUSY && if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q < n_q) cnt_d = cnt_q + 3'd1;
          if (!we_q && cnt_q != 3'd0) asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
          if (we_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IF_BUSY) begin
              if_done_d  = 1'b1;
              if_rdata_d = asm_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_d;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done           = if_done_q;
  assign if_rdata          = if_rdata_q;
  assign mem_done          = mem_done_q;
  assign mem_rdata         = mem_rdata_q;
  assign mem_stall_request = mem_req & ~mem_done_q;
  assign ram_a             = busy ? (addr_q + ADDR_W'(cnt_q)) : '0;
  assign ram_wr            = (state_q == MEM_BUSY) & we_q;
  assign ram_dout          = ram_wr ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a byte-wide RAM model (one-cycle read latency).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done, mem_stall_request;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] data;
    int          at;
    logic        ld;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  exp_t mon_if, mon_mem;

  logic [7:0] bram [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_stall_request(mem_stall_request),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM model: read data appears the cycle after the address; writes land on the edge.
  initial begin
    ram_din = 8'h00;
    for (int i = 0; i < 65536; i++) bram[i] = 8'h00;
    bram[16'h0100] = 8'h13; bram[16'h0101] = 8'h05; bram[16'h0102] = 8'ha0; bram[16'h0103] = 8'h00;
    bram[16'h0104] = 8'h93; bram[16'h0105] = 8'h05; bram[16'h0106] = 8'h10; bram[16'h0107] = 8'h00;
    bram[16'h0108] = 8'h37; bram[16'h0109] = 8'h12; bram[16'h010a] = 8'h00; bram[16'h010b] = 8'h00;
    bram[16'h0010] = 8'h5a;
    bram[16'hfffe] = 8'h11; bram[16'hffff] = 8'h22; bram[16'h0000] = 8'h33; bram[16'h0001] = 8'h44;
    for (int i = 0; i < 4; i++) bram[16'h0300 + i] = 8'haa;
    forever begin
      @(posedge clk);
      ram_din <= bram[ram_a[15:0]];
      if (ram_wr) bram[ram_a[15:0]] = ram_dout;
    end
  end

  // Scoreboard: every done pulse pops the oldest expectation for that requester.
  always @(negedge clk) begin
    if (if_done) begin
      if (if_q.size() == 0) chk("if_unexpected_done", 32'd1, 32'd0);
      else begin
        mon_if = if_q.pop_front();
        chk("if_rdata", if_rdata, mon_if.data);
        chk("if_done_cycle", 32'(cyc), 32'(mon_if.at));
      end
    end
    if (mem_done) begin
      if (mem_q.size() == 0) chk("mem_unexpected_done", 32'd1, 32'd0);
      else begin
        mon_mem = mem_q.pop_front();
        if (mon_mem.ld) chk("mem_rdata", mem_rdata, mon_mem.data);
        chk("mem_done_cycle", 32'(cyc), 32'(mon_mem.at));
      end
    end
  end

  // acc_delay = extra edges the request waits before the arbiter accepts it.
  task automatic do_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input int acc_delay);
    int cr, c0, n, idx, nlog;
    logic seen;
    exp_t e;
    logic [31:0] a_log [0:3];
    logic        w_log [0:3];
    logic [7:0]  d_log [0:3];
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    @(negedge clk);
    cr = cyc;
    c0 = cr + 1 + acc_delay;
    e.data = exp_data;
    e.at   = c0 + n + (we ? 0 : 1);
    e.ld   = !we;
    mem_q.push_back(e);
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    seen = 1'b0;
    nlog = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      idx = cyc - c0;
      if (idx >= 0 && idx < n) begin
        a_log[idx] = ram_a; w_log[idx] = ram_wr; d_log[idx] = ram_dout;
        nlog++;
      end
      chk("mem_stall", 32'(mem_stall_request), 32'(cyc != e.at));
      if (mem_done) seen = 1'b1;
    end
    if (!seen) chk("mem_timeout", 32'd0, 32'd1);
    chk("done_idle_ram_a", ram_a, 32'h0);
    chk("done_idle_ram_wr", 32'(ram_wr), 32'd0);
    mem_req = 1'b0;
    chk("mem_addr_count", 32'(nlog), 32'(n));
    for (int k = 0; k < nlog; k++) begin
      chk("mem_ram_a", a_log[k], addr + 32'(k));
      chk("mem_ram_wr", 32'(w_log[k]), 32'(we));
      if (we) chk("mem_ram_dout", 32'(d_log[k]), 32'(wdata[8*k +: 8]));
    end
  endtask

  task automatic do_if(input logic [31:0] addr, input logic [31:0] exp_data, input int acc_delay);
    int cr, c0, idx, nlog;
    logic seen;
    exp_t e;
    logic [31:0] a_log [0:3];
    logic        w_log [0:3];
    @(negedge clk);
    cr = cyc;
    c0 = cr + 1 + acc_delay;
    e.data = exp_data;
    e.at   = c0 + 5;
    e.ld   = 1'b1;
    if_q.push_back(e);
    if_req = 1'b1; if_addr = addr;
    seen = 1'b0;
    nlog = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      idx = cyc - c0;
      if (idx >= 0 && idx < 4) begin
        a_log[idx] = ram_a; w_log[idx] = ram_wr;
        nlog++;
      end
      if (if_done) seen = 1'b1;
    end
    if (!seen) chk("if_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
    chk("if_addr_count", 32'(nlog), 32'd4);
    for (int k = 0; k < nlog; k++) begin
      chk("if_ram_a", a_log[k], addr + 32'(k));
      chk("if_ram_wr", 32'(w_log[k]), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_done"}, 32'(if_done), 32'd0);
    chk({tag, "_mem_done"}, 32'(mem_done), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_ram_a"}, ram_a, 32'h0);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
  endtask

  initial begin
    int cr, nd;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_stall", 32'(mem_stall_request), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Instruction fetch from 0x100
    do_if(32'h0000_0100, 32'h00a0_0513, 0);

    // Store word, then load half from its upper half
    do_mem(1'b1, 2'd2, 32'h0000_0200, 32'hdead_beef, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sw_val;
      sw_val = 32'hdead_beef;
      chk("sw_ram_content", 32'(bram[16'h0200 + k]), 32'(sw_val[8*k +: 8]));
    end
    do_mem(1'b0, 2'd1, 32'h0000_0202, 32'h0, 32'h0000_dead, 0);

    // Simultaneous requests: MEM lb first, IF accepted after one turnaround cycle
    fork
      do_mem(1'b0, 2'd0, 32'h0000_0010, 32'h0, 32'h0000_005a, 0);
      do_if(32'h0000_0100, 32'h00a0_0513, 4);
    join

    // Flush two cycles into a fetch, then a normal fetch from 0x104
    @(negedge clk);
    cr = cyc;
    if_req = 1'b1; if_addr = 32'h0000_0108;
    while (cyc < cr + 3) @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush_idle_ram_a", ram_a, 32'h0);
    if_flush = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) nd++;
    end
    chk("flush_no_done", 32'(nd), 32'd0);
    chk("flush_rdata_hold", if_rdata, 32'h00a0_0513);
    do_if(32'h0000_0104, 32'h0010_0593, 0);

    // Address wrap-around and size 3 treated as a word
    do_mem(1'b0, 2'd2, 32'hffff_fffe, 32'h0, 32'h4433_2211, 0);
    do_mem(1'b0, 2'd3, 32'h0000_0200, 32'h0, 32'hdead_beef, 0);

    // Reset pulsed mid-store after two bytes written
    @(negedge clk);
    cr = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_0300; mem_wdata = 32'h1122_3344;
    while (cyc < cr + 3) @(negedge clk);
    chk("pre_rst_ram_wr", 32'(ram_wr), 32'd1);
    chk("pre_rst_ram_a", ram_a, 32'h0000_0302);
    #1 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_byte0", 32'(bram[16'h0300]), 32'h44);
    chk("rst_byte1", 32'(bram[16'h0301]), 32'h33);
    chk("rst_byte2", 32'(bram[16'h0302]), 32'haa);
    chk("rst_byte3", 32'(bram[16'h0303]), 32'haa);
    do_mem(1'b0, 2'd0, 32'h0000_0300, 32'h0, 32'h0000_0044, 0);
    do_mem(1'b0, 2'd2, 32'h0000_0300, 32'h0, 32'haaaa_3344, 0);

    repeat (3) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
